// File: rtl/riscv_fetch_align.sv
// riscv_fetch_align: splits word-aligned 32-bit fetch words into 16/32-bit instructions.
// Latency: an instruction completed by a word accepted at edge N is presented after edge N.
// Backpressure: fch_rdy drops when the halfword queue cannot take a full word this cycle.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   flush, flush_pc           redirect (highest priority) and its halfword target
//   fch_vld/fch_rdy/fch_dat   fetch word stream, [15:0] is the lower halfword
//   dec_vld/dec_rdy           instruction handshake towards the decoder
//   dec_ins/dec_rvc/dec_pc    instruction, compressed flag, instruction address
module riscv_fetch_align #(
  parameter int unsigned    PCW    = 32,
  parameter logic [PCW-1:0] PC_RST = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [PCW-1:0] flush_pc,
  input  logic           fch_vld,
  output logic           fch_rdy,
  input  logic [31:0]    fch_dat,
  output logic           dec_vld,
  input  logic           dec_rdy,
  output logic [31:0]    dec_ins,
  output logic           dec_rvc,
  output logic [PCW-1:0] dec_pc
);

  localparam logic [PCW-1:0] HALF_MASK = ~PCW'(1);

  logic [15:0]    q [4];
  logic [2:0]     cnt;
  logic [PCW-1:0] pc;
  logic           skip;

  logic [15:0]    nq [4];
  logic [2:0]     ncnt;
  logic [2:0]     rem;
  logic [1:0]     pop;
  logic           push;
  logic           head_rvc;

  assign head_rvc = (q[0][1:0] != 2'b11);
  assign dec_vld  = !flush && ((cnt >= 3'd2) || ((cnt == 3'd1) && head_rvc));
  assign dec_rvc  = head_rvc;
  assign dec_ins  = head_rvc ? {16'h0000, q[0]} : {q[1], q[0]};
  assign dec_pc   = pc;

  // Halfwords leaving this cycle; dec_vld guarantees pop never exceeds cnt.
  assign pop  = (dec_vld && dec_rdy) ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign rem  = cnt - {1'b0, pop};
  // Ready depends on this cycle's pop so a full queue can still stream at
  // one instruction per cycle; rem <= 2 keeps the queue within 4 entries.
  assign fch_rdy = flush || (rem <= 3'd2);
  assign push    = fch_vld && fch_rdy && !flush;

  always_comb begin
    for (int i = 0; i < 4; i++) nq[i] = 16'h0000;
    // Pop first, then append behind the survivors.
    case (pop)
      2'd1: begin
        nq[0] = q[1]; nq[1] = q[2]; nq[2] = q[3];
      end
      2'd2: begin
        nq[0] = q[2]; nq[1] = q[3];
      end
      default: begin
        for (int i = 0; i < 4; i++) nq[i] = q[i];
      end
    endcase
    ncnt = rem;
    if (push) begin
      if (skip) begin
        // Redirect to an odd halfword: the lower half of this word is not ours.
        for (int i = 0; i < 4; i++)
          if (rem == 3'(i)) nq[i] = fch_dat[31:16];
        ncnt = rem + 3'd1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (rem == 3'(i))         nq[i] = fch_dat[15:0];
          if (rem + 3'd1 == 3'(i))  nq[i] = fch_dat[31:16];
        end
        ncnt = rem + 3'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i] <= 16'h0000;
      cnt  <= 3'd0;
      pc   <= PC_RST & HALF_MASK;
      skip <= PC_RST[1];
    end else if (flush) begin
      for (int i = 0; i < 4; i++) q[i] <= 16'h0000;
      cnt  <= 3'd0;
      pc   <= flush_pc & HALF_MASK;
      skip <= flush_pc[1];
    end else begin
      for (int i = 0; i < 4; i++) q[i] <= nq[i];
      cnt <= ncnt;
      if (push) skip <= 1'b0;
      case (pop)
        2'd1:    pc <= pc + PCW'(2);
        2'd2:    pc <= pc + PCW'(4);
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Directed bench for riscv_fetch_align with hand-computed expected values.
module tb_riscv_fetch_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        fch_vld = 1'b0;
  logic        fch_rdy;
  logic [31:0] fch_dat = 32'h0;
  logic        dec_vld;
  logic        dec_rdy = 1'b0;
  logic [31:0] dec_ins;
  logic        dec_rvc;
  logic [31:0] dec_pc;

  int checks = 0;
  int errors = 0;

  riscv_fetch_align #(.PCW(32), .PC_RST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fch_vld(fch_vld), .fch_rdy(fch_rdy), .fch_dat(fch_dat),
    .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_ins(dec_ins),
    .dec_rvc(dec_rvc), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fch_vld = 1'b0; dec_rdy = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  int acc;
  int emit;

  initial begin
    // Reset state
    #2;
    chk("rst_vld", {31'h0, dec_vld}, 32'h0);
    chk("rst_ins", dec_ins, 32'h0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_fch_rdy", {31'h0, fch_rdy}, 32'h1);
    tick();
    rst = 1'b0;

    // 1: aligned 32-bit addi
    fch_vld = 1'b1; fch_dat = 32'h0000_0013; dec_rdy = 1'b0;
    tick();
    fch_vld = 1'b0; #1;
    chk("t1_vld", {31'h0, dec_vld}, 32'h1);
    chk("t1_ins", dec_ins, 32'h0000_0013);
    chk("t1_rvc", {31'h0, dec_rvc}, 32'h0);
    chk("t1_pc", dec_pc, 32'h0);

    // 2: two compressed in one word
    do_reset();
    tick();
    fch_vld = 1'b1; fch_dat = 32'h0001_4501; dec_rdy = 1'b1;
    tick();
    fch_vld = 1'b0; #1;
    chk("t2_ins0", dec_ins, 32'h0000_4501);
    chk("t2_pc0", dec_pc, 32'h0);
    chk("t2_rvc0", {31'h0, dec_rvc}, 32'h1);
    tick();
    chk("t2_ins1", dec_ins, 32'h0000_0001);
    chk("t2_pc1", dec_pc, 32'h2);
    chk("t2_rvc1", {31'h0, dec_rvc}, 32'h1);
    tick();
    chk("t2_empty", {31'h0, dec_vld}, 32'h0);

    // 3: 32-bit instruction straddling two words with a fetch gap
    do_reset();
    tick();
    fch_vld = 1'b1; fch_dat = 32'h0013_4501; dec_rdy = 1'b1;
    tick();
    fch_vld = 1'b0; #1;
    chk("t3_cli", dec_ins, 32'h0000_4501);
    chk("t3_cli_pc", dec_pc, 32'h0);
    tick();
    chk("t3_gap0", {31'h0, dec_vld}, 32'h0);
    tick();
    chk("t3_gap1", {31'h0, dec_vld}, 32'h0);
    tick();
    fch_vld = 1'b1; fch_dat = 32'h0001_0000; #1;
    chk("t3_gap2", {31'h0, dec_vld}, 32'h0);
    tick();
    fch_vld = 1'b0; #1;
    chk("t3_ins32", dec_ins, 32'h0000_0013);
    chk("t3_rvc32", {31'h0, dec_rvc}, 32'h0);
    chk("t3_pc32", dec_pc, 32'h2);
    chk("t3_vld32", {31'h0, dec_vld}, 32'h1);
    tick();
    chk("t3_ins_c", dec_ins, 32'h0000_0001);
    chk("t3_pc_c", dec_pc, 32'h6);
    chk("t3_vld_c", {31'h0, dec_vld}, 32'h1);

    // 4: flush to an odd halfword target drops the lower half
    flush = 1'b1; flush_pc = 32'h0000_0102; dec_rdy = 1'b1; #1;
    chk("t4_flush_vld", {31'h0, dec_vld}, 32'h0);
    tick();
    flush = 1'b0; #1;
    chk("t4_pc_after", dec_pc, 32'h102);
    chk("t4_vld_after", {31'h0, dec_vld}, 32'h0);
    fch_vld = 1'b1; fch_dat = 32'h0001_0013;
    tick();
    fch_vld = 1'b0; #1;
    chk("t4_vld", {31'h0, dec_vld}, 32'h1);
    chk("t4_ins", dec_ins, 32'h0000_0001);
    chk("t4_pc", dec_pc, 32'h102);
    chk("t4_rvc", {31'h0, dec_rvc}, 32'h1);
    tick();
    chk("t4_single", {31'h0, dec_vld}, 32'h0);
    chk("t4_pc_next", dec_pc, 32'h104);

    // 5: backpressure fills the queue, then drain
    do_reset();
    tick();
    acc = 0;
    fch_vld = 1'b1; fch_dat = 32'h0000_0013; dec_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fch_rdy) acc++;
      tick();
      if (i > 0) begin
        chk("t5_frz_ins", dec_ins, 32'h0000_0013);
        chk("t5_frz_pc", dec_pc, 32'h0);
      end
    end
    chk("t5_full_rdy", {31'h0, fch_rdy}, 32'h0);
    chk("t5_accepted", acc, 2);
    fch_vld = 1'b0; dec_rdy = 1'b1; #1;
    // Full queue with a 32-bit head: popping two makes room combinationally.
    chk("t5_rdy_path", {31'h0, fch_rdy}, 32'h1);
    emit = 0;
    for (int i = 0; i < 4; i++) begin
      if (dec_vld) begin
        chk("t5_drain_ins", dec_ins, 32'h0000_0013);
        chk("t5_drain_pc", dec_pc, 32'(emit * 4));
        emit++;
      end
      tick();
    end
    chk("t5_emitted", emit, 2);

    // 6: flush together with fetch and decode handshakes, then async reset
    do_reset();
    tick();
    fch_vld = 1'b1; fch_dat = 32'h0000_0013; dec_rdy = 1'b0;
    tick();
    flush = 1'b1; flush_pc = 32'h0000_0040; dec_rdy = 1'b1; #1;
    chk("t6_flush_vld", {31'h0, dec_vld}, 32'h0);
    chk("t6_flush_rdy", {31'h0, fch_rdy}, 32'h1);
    tick();
    flush = 1'b0; fch_vld = 1'b0; #1;
    chk("t6_pc", dec_pc, 32'h40);
    chk("t6_discard", {31'h0, dec_vld}, 32'h0);
    fch_vld = 1'b1; dec_rdy = 1'b0;
    tick();
    fch_vld = 1'b0; #1;
    chk("t6_refetch_vld", {31'h0, dec_vld}, 32'h1);
    chk("t6_refetch_pc", dec_pc, 32'h40);
    rst = 1'b1; #1;
    chk("t6_rst_vld", {31'h0, dec_vld}, 32'h0);
    chk("t6_rst_pc", dec_pc, 32'h0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
